// File: rtl/nios_system_pio_multi.sv
// nios_system_pio_multi
//   Avalon-MM general-purpose I/O port. WIDTH input channels are synchronised,
//   debounced and edge-detected into a sticky capture register. Each bit can
//   select rising and/or falling edges and can be masked onto irq. WIDTH output
//   channels sit behind a data register with atomic set/clear aliases.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register select (0 DATA, 1 OUT, 2 MASK, 3 CAPTURE,
//               4 RISE, 5 FALL, 6 OUTSET, 7 OUTCLR)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (only [WIDTH-1:0] is used)
//   in_port     asynchronous external inputs
//   out_port    output data register
//   irq         level interrupt, |(edge_capture & irq_mask)
//   readdata    registered read data, 1-cycle latency
module nios_system_pio_multi #(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 1,
   parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq,
   output logic [31:0]      readdata
);

   localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      REG_DATA    = 3'd0,
      REG_OUT     = 3'd1,
      REG_MASK    = 3'd2,
      REG_CAPTURE = 3'd3,
      REG_RISE    = 3'd4,
      REG_FALL    = 3'd5,
      REG_OUTSET  = 3'd6,
      REG_OUTCLR  = 3'd7
   } reg_addr_t;

   reg_addr_t        reg_sel;
   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] filt_d;
   logic [CW-1:0]    cnt [WIDTH];

   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;

   logic [WIDTH-1:0] edge_ev;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] rd_mux;

   assign reg_sel   = reg_addr_t'(address);
   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   // Upper writedata bits are intentionally ignored.
   assign unused_wd = ^writedata;

   assign edge_ev = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
   assign irq     = |(edge_capture & irq_mask);

   always_comb begin
      cap_clr = '0;
      if (wr && reg_sel == REG_CAPTURE) begin
         cap_clr = wd;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_DATA:    rd_mux = filt;
         REG_OUT:     rd_mux = out_port;
         REG_MASK:    rd_mux = irq_mask;
         REG_CAPTURE: rd_mux = edge_capture;
         REG_RISE:    rd_mux = rise_en;
         REG_FALL:    rd_mux = fall_en;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1        <= '0;
         sync_s       <= '0;
         filt         <= '0;
         filt_d       <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         out_port     <= OUT_RESET;
         irq_mask     <= '0;
         edge_capture <= '0;
         rise_en      <= '1;
         fall_en      <= '0;
         readdata     <= '0;
      end else begin
         sync1  <= in_port;
         sync_s <= sync1;
         filt_d <= filt;

         // Per-bit debounce: a differing synchronised value must persist
         // for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               filt[i] <= sync_s[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end

         // A new event overrides a same-cycle write-1-to-clear.
         edge_capture <= (edge_capture & ~cap_clr) | edge_ev;

         if (wr) begin
            case (reg_sel)
               REG_OUT:    out_port <= wd;
               REG_MASK:   irq_mask <= wd;
               REG_RISE:   rise_en  <= wd;
               REG_FALL:   fall_en  <= wd;
               REG_OUTSET: out_port <= out_port | wd;
               REG_OUTCLR: out_port <= out_port & ~wd;
               default:    ;
            endcase
         end

         readdata <= 32'(rd_mux);
      end
   end

endmodule

// File: tb/tb_nios_system_pio_multi.sv
// Testbench for nios_system_pio_multi: two instances (DEBOUNCE_CYCLES 1 and 4)
// share one bus and one input vector and are compared every cycle against a
// behavioural model, plus directed constant checks from the register map.
module tb_nios_system_pio_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;

   logic [7:0]  out0, out1;
   logic        irq0, irq1;
   logic [31:0] rd0, rd1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   nios_system_pio_multi #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .OUT_RESET(8'hA5)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .out_port(out0), .irq(irq0), .readdata(rd0));

   nios_system_pio_multi #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .OUT_RESET(8'h00)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .out_port(out1), .irq(irq1), .readdata(rd1));

   // Behavioural model state; run[i] is how long the synchronised input has
   // disagreed with the accepted value.
   typedef struct {
      logic [7:0]  sync1, s, f, fd, out, mask, cap, rise, fall;
      logic [31:0] rd;
      int          run [8];
   } mstate_t;

   mstate_t m [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mstate_t step(mstate_t c, int k);
      mstate_t    n;
      logic [7:0] wd;
      logic [7:0] ev;
      bit         wr;
      int         deb;
      n   = c;
      wd  = writedata[7:0];
      wr  = chipselect && !write_n;
      deb = (k == 0) ? 1 : 4;
      if (reset) begin
         n.sync1 = 8'h00; n.s = 8'h00; n.f = 8'h00; n.fd = 8'h00;
         n.out   = (k == 0) ? 8'hA5 : 8'h00;
         n.mask  = 8'h00; n.cap = 8'h00; n.rise = 8'hFF; n.fall = 8'h00;
         n.rd    = 32'h0;
         for (int i = 0; i < 8; i++) n.run[i] = 0;
         return n;
      end
      case (address)
         3'd0: n.rd = {24'h0, c.f};
         3'd1: n.rd = {24'h0, c.out};
         3'd2: n.rd = {24'h0, c.mask};
         3'd3: n.rd = {24'h0, c.cap};
         3'd4: n.rd = {24'h0, c.rise};
         3'd5: n.rd = {24'h0, c.fall};
         default: n.rd = 32'h0;
      endcase
      ev = (c.f & ~c.fd & c.rise) | (~c.f & c.fd & c.fall);
      if (wr) begin
         case (address)
            3'd1: n.out  = wd;
            3'd2: n.mask = wd;
            3'd3: n.cap  = c.cap & ~wd;
            3'd4: n.rise = wd;
            3'd5: n.fall = wd;
            3'd6: n.out  = c.out | wd;
            3'd7: n.out  = c.out & ~wd;
            default: ;
         endcase
      end
      n.cap = n.cap | ev;
      for (int i = 0; i < 8; i++) begin
         if (c.s[i] != c.f[i]) begin
            n.run[i] = c.run[i] + 1;
            if (n.run[i] >= deb) begin
               n.f[i]   = c.s[i];
               n.run[i] = 0;
            end
         end else begin
            n.run[i] = 0;
         end
      end
      n.fd    = c.f;
      n.s     = c.sync1;
      n.sync1 = in_port;
      return n;
   endfunction

   task automatic tick();
      mstate_t nx0, nx1;
      nx0 = step(m[0], 0);
      nx1 = step(m[1], 1);
      @(posedge clk);
      #1;
      m[0] = nx0;
      m[1] = nx1;
      check("out0", {24'h0, out0}, {24'h0, m[0].out});
      check("irq0", {31'h0, irq0}, {31'h0, |(m[0].cap & m[0].mask)});
      check("rd0", rd0, m[0].rd);
      check("out1", {24'h0, out1}, {24'h0, m[1].out});
      check("irq1", {31'h0, irq1}, {31'h0, |(m[1].cap & m[1].mask)});
      check("rd1", rd1, m[1].rd);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input int k, input logic [2:0] a, input logic [7:0] exp);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick();
      check($sformatf("read%0d_a%0d", k, a), (k == 0) ? rd0 : rd1, {24'h0, exp});
      chipselect = 1'b0;
   endtask

   initial begin
      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; in_port = 8'h00;
      ticks(3);
      reset = 1'b0;
      check("rst_out0", {24'h0, out0}, 32'hA5);
      check("rst_irq0", {31'h0, irq0}, 32'h0);
      check("rst_rd0", rd0, 32'h0);
      bus_read(0, 3'd2, 8'h00);
      bus_read(0, 3'd3, 8'h00);
      bus_read(0, 3'd4, 8'hFF);
      bus_read(0, 3'd5, 8'h00);

      // Rising edge on bit 0 with DEB=1: irq after the fourth edge.
      bus_write(3'd2, 32'h01);
      in_port = 8'h01;
      ticks(3);
      check("irq_early", {31'h0, irq0}, 32'h0);
      tick();
      check("irq_rise", {31'h0, irq0}, 32'h1);
      bus_write(3'd3, 32'h01);
      check("irq_clr", {31'h0, irq0}, 32'h0);
      in_port = 8'h00;
      ticks(6);
      bus_read(0, 3'd3, 8'h00);

      // Debounce on the DEB=4 instance.
      bus_write(3'd3, 32'hFF);
      in_port = 8'h04;
      ticks(3);
      in_port = 8'h00;
      ticks(10);
      bus_read(1, 3'd0, 8'h00);
      bus_read(1, 3'd3, 8'h00);
      in_port = 8'h04;
      ticks(10);
      bus_read(1, 3'd0, 8'h04);
      bus_read(1, 3'd3, 8'h04);

      // Falling-only detection and event-beats-clear.
      bus_write(3'd4, 32'h00);
      bus_write(3'd5, 32'hFF);
      in_port = 8'h80;
      ticks(10);
      bus_write(3'd3, 32'hFF);
      in_port = 8'h00;
      ticks(10);
      bus_read(0, 3'd3, 8'h80);
      in_port = 8'h80;
      ticks(10);
      in_port = 8'h00;
      ticks(3);
      bus_write(3'd3, 32'h80);
      bus_read(0, 3'd3, 8'h80);
      bus_write(3'd3, 32'h80);
      bus_read(0, 3'd3, 8'h00);

      // Output register and aliases.
      bus_write(3'd1, 32'hFFFF_FF0F);
      check("out_wr", {24'h0, out0}, 32'h0F);
      bus_write(3'd6, 32'h30);
      check("out_set", {24'h0, out0}, 32'h3F);
      bus_write(3'd7, 32'h03);
      check("out_clr", {24'h0, out0}, 32'h3C);
      bus_write(3'd0, 32'hFF);
      bus_write(3'd3, 32'h00);
      check("out_keep", {24'h0, out0}, 32'h3C);
      bus_read(0, 3'd1, 8'h3C);
      bus_read(0, 3'd6, 8'h00);

      // Input held high through reset yields a post-reset rising capture.
      in_port = 8'hFF;
      reset = 1'b1;
      ticks(3);
      reset = 1'b0;
      ticks(6);
      bus_read(0, 3'd3, 8'hFF);
      check("irq_masked", {31'h0, irq0}, 32'h0);
      bus_write(3'd2, 32'h01);
      check("irq_unmask", {31'h0, irq0}, 32'h1);

      // Randomised traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(7) == 0) in_port[b] = ~in_port[b];
         end
         chipselect = ($urandom_range(3) != 0);
         write_n    = $urandom_range(1) != 0;
         address    = 3'($urandom_range(7));
         writedata  = $urandom;
         reset      = ($urandom_range(299) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
